tea_iter_engine: RTL and testbench

Iterative, parametrised TEA/XTEA block-cipher engine; successor to the fixed 32-round, separate cipher/decipher `dut`. One engine performs encrypt or decrypt, selected per block, at one full cycle (both half-rounds) per clock. It has a start/ready/done handshake and holds its outputs until the next block. It sits between the key/data register file and the bus-side result registers.

---
 rtl/tea_pkg.sv | 22 ++
 rtl/tea_round.sv | 83 ++++++++
 rtl/tea_iter_engine.sv | 138 +++++++++++++
 tb/tb_tea_iter_engine.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared definitions for the iterative TEA/XTEA engine: default key-schedule
// constant, FSM state encoding and the initial decrypt-sum helper.
package tea_pkg;

  localparam logic [31:0] DEFAULT_DELTA = 32'h9e3779b9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide product; the caller truncates to its word size, which equals
  // truncating DELTA first because only the low bits survive the modulo.
  function automatic logic [63:0] init_decrypt_sum(input logic [31:0] delta,
                                                   input int unsigned rounds);
    logic [63:0] wide_delta;
    wide_delta = {32'd0, delta};
    return wide_delta * 64'(rounds);
  endfunction

endpackage

// File: rtl/tea_round.sv
// One full TEA/XTEA cycle (both half-rounds) in either direction, purely combinational.
// XTEA datapath is present only when TEA_XTEA_EN is defined.
module tea_round
  import tea_pkg::*;
#(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] DELTA     = WORD_SIZE'(DEFAULT_DELTA)
) (
  input  logic [WORD_SIZE-1:0] v0,
  input  logic [WORD_SIZE-1:0] v1,
  input  logic [WORD_SIZE-1:0] sum,
  input  logic [WORD_SIZE-1:0] k0,
  input  logic [WORD_SIZE-1:0] k1,
  input  logic [WORD_SIZE-1:0] k2,
  input  logic [WORD_SIZE-1:0] k3,
  input  logic                 decipher,
  input  logic                 mode,
  output logic [WORD_SIZE-1:0] v0_next,
  output logic [WORD_SIZE-1:0] v1_next,
  output logic [WORD_SIZE-1:0] sum_next
);

  function automatic logic [WORD_SIZE-1:0] tea_f(input logic [WORD_SIZE-1:0] x,
                                                 input logic [WORD_SIZE-1:0] ka,
                                                 input logic [WORD_SIZE-1:0] kb,
                                                 input logic [WORD_SIZE-1:0] s);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

`ifdef TEA_XTEA_EN
  function automatic logic [WORD_SIZE-1:0] xtea_mix(input logic [WORD_SIZE-1:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  function automatic logic [WORD_SIZE-1:0] key_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    return k0;
      2'd1:    return k1;
      2'd2:    return k2;
      default: return k3;
    endcase
  endfunction
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  logic [WORD_SIZE-1:0] mid_sum;

  always_comb begin
    mid_sum  = sum;
    v0_next  = v0;
    v1_next  = v1;
    sum_next = sum;
`ifdef TEA_XTEA_EN
    if (mode) begin
      // XTEA: the sum steps between the two half-rounds, so each half keys off a different sum
      if (!decipher) begin
        v0_next  = v0 + (xtea_mix(v1) ^ (sum + key_sel(sum[1:0])));
        mid_sum  = sum + DELTA;
        v1_next  = v1 + (xtea_mix(v0_next) ^ (mid_sum + key_sel(mid_sum[12:11])));
        sum_next = mid_sum;
      end else begin
        v1_next  = v1 - (xtea_mix(v0) ^ (sum + key_sel(sum[12:11])));
        mid_sum  = sum - DELTA;
        v0_next  = v0 - (xtea_mix(v1_next) ^ (mid_sum + key_sel(mid_sum[1:0])));
        sum_next = mid_sum;
      end
    end else
`endif
    if (!decipher) begin
      mid_sum  = sum + DELTA;
      v0_next  = v0 + tea_f(v1, k0, k1, mid_sum);
      v1_next  = v1 + tea_f(v0_next, k2, k3, mid_sum);
      sum_next = mid_sum;
    end else begin
      v1_next  = v1 - tea_f(v0, k2, k3, sum);
      v0_next  = v0 - tea_f(v1_next, k0, k1, sum);
      sum_next = sum - DELTA;
    end
  end

endmodule

// File: rtl/tea_iter_engine.sv
// Iterative TEA/XTEA engine with start/ready/done handshake, one cycle per clock.
// Define TEA_XTEA_EN to build the XTEA datapath and honour iMode.
module tea_iter_engine
  import tea_pkg::*;
#(
  parameter int          WORD_SIZE    = 32,
  parameter logic [31:0] DELTA        = DEFAULT_DELTA,
  parameter int          ROUND_NUMBER = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iStart,
  input  logic                 iDecipher,
  input  logic                 iMode,
  input  logic [WORD_SIZE-1:0] iV0,
  input  logic [WORD_SIZE-1:0] iV1,
  input  logic [WORD_SIZE-1:0] iK0,
  input  logic [WORD_SIZE-1:0] iK1,
  input  logic [WORD_SIZE-1:0] iK2,
  input  logic [WORD_SIZE-1:0] iK3,
  output logic                 oReady,
  output logic                 oDone,
  output logic [WORD_SIZE-1:0] oC0,
  output logic [WORD_SIZE-1:0] oC1
);

  localparam logic [WORD_SIZE-1:0] DELTA_W     = WORD_SIZE'(DELTA);
  localparam logic [WORD_SIZE-1:0] DECRYPT_SUM =
    WORD_SIZE'(init_decrypt_sum(DELTA, ROUND_NUMBER));
  localparam logic [7:0]           LAST_COUNT  = 8'(ROUND_NUMBER - 1);

  state_t state, next_state;
  logic   accept, finish;

  logic [7:0]           count;
  logic [WORD_SIZE-1:0] v0, v1, sum;
  logic [WORD_SIZE-1:0] k0, k1, k2, k3;
  logic                 decipher;
  logic                 mode;
  logic [WORD_SIZE-1:0] v0_next, v1_next, sum_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A start is only honoured while ready; DONE accepts directly for back-to-back blocks
  always_comb begin
    next_state = state;
    oReady     = 1'b0;
    oDone      = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        oReady = 1'b1;
        accept = iStart;
        if (iStart) next_state = RUN;
      end
      RUN: begin
        finish = (count == LAST_COUNT);
        if (finish) next_state = DONE;
      end
      DONE: begin
        oReady     = 1'b1;
        oDone      = 1'b1;
        accept     = iStart;
        next_state = iStart ? RUN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      v0       <= '0;
      v1       <= '0;
      sum      <= '0;
      k0       <= '0;
      k1       <= '0;
      k2       <= '0;
      k3       <= '0;
      decipher <= 1'b0;
      oC0      <= '0;
      oC1      <= '0;
    end else if (accept) begin
      count    <= '0;
      v0       <= iV0;
      v1       <= iV1;
      sum      <= iDecipher ? DECRYPT_SUM : '0;
      k0       <= iK0;
      k1       <= iK1;
      k2       <= iK2;
      k3       <= iK3;
      decipher <= iDecipher;
    end else if (state == RUN) begin
      count <= count + 8'd1;
      v0    <= v0_next;
      v1    <= v1_next;
      sum   <= sum_next;
      if (finish) begin
        oC0 <= v0_next;
        oC1 <= v1_next;
      end
    end
  end

`ifdef TEA_XTEA_EN
  always_ff @(posedge clk) begin
    if (rst)         mode <= 1'b0;
    else if (accept) mode <= iMode;
  end
`else
  logic unused_imode;
  assign unused_imode = iMode;
  assign mode         = 1'b0;
`endif

  tea_round #(
    .WORD_SIZE(WORD_SIZE),
    .DELTA    (DELTA_W)
  ) u_round (
    .v0      (v0),
    .v1      (v1),
    .sum     (sum),
    .k0      (k0),
    .k1      (k1),
    .k2      (k2),
    .k3      (k3),
    .decipher(decipher),
    .mode    (mode),
    .v0_next (v0_next),
    .v1_next (v1_next),
    .sum_next(sum_next)
  );

endmodule

// File: tb/tb_tea_iter_engine.sv
// Directed bench for tea_iter_engine at default parameters: known TEA/XTEA vectors,
// round trips, latency, back-to-back handshake and mid-block reset.
module tb_tea_iter_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        iStart;
  logic        iDecipher;
  logic        iMode;
  logic [31:0] iV0, iV1, iK0, iK1, iK2, iK3;
  logic        oReady;
  logic        oDone;
  logic [31:0] oC0, oC1;

  int total = 0;
  int bad   = 0;

  tea_iter_engine dut (
    .clk      (clk),
    .rst      (rst),
    .iStart   (iStart),
    .iDecipher(iDecipher),
    .iMode    (iMode),
    .iV0      (iV0),
    .iV1      (iV1),
    .iK0      (iK0),
    .iK1      (iK1),
    .iK2      (iK2),
    .iK3      (iK3),
    .oReady   (oReady),
    .oDone    (oDone),
    .oC0      (oC0),
    .oC1      (oC1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Accepts one block, scrambles the inputs during RUN, and returns the latency
  // counted in edges from the accept edge inclusive up to the one raising oDone.
  task automatic applyStimulus(input logic dec, input logic mode,
                               input logic [31:0] v0, input logic [31:0] v1,
                               input logic [31:0] k0, input logic [31:0] k1,
                               input logic [31:0] k2, input logic [31:0] k3,
                               output int lat);
    iDecipher = dec;
    iMode     = mode;
    iV0 = v0; iV1 = v1;
    iK0 = k0; iK1 = k1; iK2 = k2; iK3 = k3;
    iStart = 1'b1;
    stepClock();
    iStart    = 1'b0;
    iDecipher = ~dec;
    iV0 = ~v0; iV1 = ~v1;
    iK0 = ~k0; iK1 = ~k1; iK2 = ~k2; iK3 = ~k3;
    lat = 1;
    while (oDone !== 1'b1 && lat < 200) begin
      stepClock();
      lat++;
    end
  endtask

  int          lat;
  int          pulses;
  int          first_pulse;
  int          second_pulse;
  logic        ready_mid;
  logic [31:0] enc0, enc1;

  initial begin
    rst = 1'b1; iStart = 1'b0; iDecipher = 1'b0; iMode = 1'b0;
    iV0 = '0; iV1 = '0; iK0 = '0; iK1 = '0; iK2 = '0; iK3 = '0;
    stepClock();
    stepClock();
    rst = 1'b0;
    stepClock();
    checkOutput("reset_ready", 64'(oReady), 64'd1);
    checkOutput("reset_done",  64'(oDone),  64'd0);
    checkOutput("reset_c0",    64'(oC0),    64'd0);
    checkOutput("reset_c1",    64'(oC1),    64'd0);

    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    checkOutput("zero_enc_latency", 64'(lat), 64'd33);
    checkOutput("zero_enc_c0", 64'(oC0), 64'h41EA3A0A);
    checkOutput("zero_enc_c1", 64'(oC1), 64'h94BAA940);
    checkOutput("done_ready",  64'(oReady), 64'd1);
    stepClock();
    checkOutput("done_single_pulse", 64'(oDone), 64'd0);
    checkOutput("idle_ready",        64'(oReady), 64'd1);
    checkOutput("hold_c0",           64'(oC0), 64'h41EA3A0A);

    applyStimulus(1'b1, 1'b0, 32'h41EA3A0A, 32'h94BAA940, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    checkOutput("zero_dec_latency", 64'(lat), 64'd33);
    checkOutput("zero_dec_c0", 64'(oC0), 64'h0);
    checkOutput("zero_dec_c1", 64'(oC1), 64'h0);
    stepClock();

    applyStimulus(1'b0, 1'b0, 32'h3D45F7A7, 32'h235FCB21,
                  32'h132ACF42, 32'h234ACB45, 32'h3235ACBE, 32'h4533F235, lat);
    enc0 = oC0;
    enc1 = oC1;
    stepClock();
    applyStimulus(1'b1, 1'b0, enc0, enc1,
                  32'h132ACF42, 32'h234ACB45, 32'h3235ACBE, 32'h4533F235, lat);
    checkOutput("trip_c0", 64'(oC0), 64'h3D45F7A7);
    checkOutput("trip_c1", 64'(oC1), 64'h235FCB21);
    stepClock();

`ifdef TEA_XTEA_EN
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    checkOutput("xtea_enc_c0", 64'(oC0), 64'hDEE9D4D8);
    checkOutput("xtea_enc_c1", 64'(oC1), 64'hF7131ED9);
    stepClock();
    applyStimulus(1'b1, 1'b1, 32'hDEE9D4D8, 32'hF7131ED9, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    checkOutput("xtea_dec_c0", 64'(oC0), 64'h0);
    checkOutput("xtea_dec_c1", 64'(oC1), 64'h0);
    stepClock();
`else
    // Without XTEA built, iMode must be ignored and TEA used
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, lat);
    checkOutput("mode_ignored_c0", 64'(oC0), 64'h41EA3A0A);
    checkOutput("mode_ignored_c1", 64'(oC1), 64'h94BAA940);
    stepClock();
`endif

    // Back-to-back: iStart held high through RUN and DONE, dropped after the second accept
    iDecipher = 1'b0; iMode = 1'b0;
    iV0 = '0; iV1 = '0; iK0 = '0; iK1 = '0; iK2 = '0; iK3 = '0;
    iStart = 1'b1;
    stepClock();
    pulses = 0; first_pulse = 0; second_pulse = 0; ready_mid = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      stepClock();
      if (n == 10) ready_mid = oReady;
      if (oDone) begin
        pulses++;
        if (pulses == 1) first_pulse = n;
        if (pulses == 2) second_pulse = n;
      end else if (pulses >= 1) begin
        iStart = 1'b0;
      end
    end
    checkOutput("b2b_ready_in_run", 64'(ready_mid), 64'd0);
    checkOutput("b2b_pulse_count",  64'(pulses), 64'd2);
    checkOutput("b2b_first_pulse",  64'(first_pulse), 64'd32);
    checkOutput("b2b_spacing",      64'(second_pulse - first_pulse), 64'd33);
    checkOutput("b2b_c0",           64'(oC0), 64'h41EA3A0A);

    // Reset mid-block, with a simultaneous start that reset must override
    iStart = 1'b1;
    stepClock();
    iStart = 1'b0;
    for (int n = 0; n < 10; n++) stepClock();
    checkOutput("abort_busy", 64'(oReady), 64'd0);
    rst = 1'b1;
    iStart = 1'b1;
    stepClock();
    rst = 1'b0;
    iStart = 1'b0;
    checkOutput("abort_ready", 64'(oReady), 64'd1);
    checkOutput("abort_c0",    64'(oC0), 64'd0);
    checkOutput("abort_c1",    64'(oC1), 64'd0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      stepClock();
      if (oDone) pulses++;
    end
    checkOutput("abort_no_done",    64'(pulses), 64'd0);
    checkOutput("abort_still_idle", 64'(oReady), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
